bus_cpu_core_p: RTL and testbench

- Parametrised successor to the single-bus CPU core. Keeps the same datapath idea: general registers, an adder input/output register pair, an address register, a PC, and one internal data bus driven by a select mux.
- Adds what the old core lacks: an instruction register, a control FSM that fetches and executes a small ISA, a full read/write bus handshake with wait states, configurable width and register count, and a debug read port.
- Sits between the top level and the memory/peripheral bus slave.

---
 rtl/bus_cpu_core_p_if.sv | 23 ++
 rtl/bus_cpu_core_p.sv | 237 +++++++++++++++++++++++
 tb/tb_bus_cpu_core_p.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cpu_core_p_if.sv
// Request/response bus between the CPU core (master) and a memory or peripheral slave.
// The master holds a request stable until the slave answers with SLAVE_READY.
interface bus_cpu_core_p_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] ADDR_BUS;
    logic [DATA_W-1:0] DATA_WBUS;
    logic [DATA_W-1:0] DATA_RBUS;
    logic              BUS_VALID;
    logic              BUS_WE;
    logic              SLAVE_READY;

    modport master (
        output ADDR_BUS, DATA_WBUS, BUS_VALID, BUS_WE,
        input  DATA_RBUS, SLAVE_READY
    );

    modport slave (
        input  ADDR_BUS, DATA_WBUS, BUS_VALID, BUS_WE,
        output DATA_RBUS, SLAVE_READY
    );
endinterface

// File: rtl/bus_cpu_core_p.sv
// Single-bus CPU core: register file, adder in/out pair, address register, PC and IR,
// sequenced by a fetch/execute FSM over a valid/ready bus with wait states.
module bus_cpu_core_p #(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              NREG     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RUN,
    bus_cpu_core_p_if.master  bus,
    output logic              HALTED,
    input  logic [3:0]        DBG_SEL,
    output logic [DATA_W-1:0] DBG_DATA
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXE_NOP, S_EXE_MOV, S_EXE_LDI, S_EXE_JMP, S_EXE_JZ,
        S_ALU_A, S_ALU_B, S_ALU_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_DONE, S_HALT
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_LDI  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_LD   = 4'd5;
    localparam logic [3:0] OP_ST   = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_JZ   = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd9;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [16];
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [31:0]       ir_q, ir_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] ain_q, ain_d, aout_q, aout_d, wbus_q, wbus_d;
    logic              valid_q, valid_d, we_q, we_d, halted_q, halted_d;

    logic              reg_we_s;
    logic [3:0]        reg_wsel_s;
    logic [DATA_W-1:0] int_bus_s;
    logic [3:0]        op_s, rd_s, rs_s;
    logic [DATA_W-1:0] rd_val_s, rs_val_s, imm_d_s;
    logic [ADDR_W-1:0] imm_a_s;
    logic              unused_ir_s;

    assign op_s        = ir_q[31:28];
    assign rd_s        = ir_q[27:24];
    assign rs_s        = ir_q[23:20];
    assign imm_d_s     = DATA_W'(ir_q[15:0]);
    assign imm_a_s     = ADDR_W'(ir_q[15:0]);
    assign unused_ir_s = ^ir_q[19:16];
    // Slots at or above NREG are never written, so they always read back as zero.
    assign rd_val_s    = regs_q[rd_s];
    assign rs_val_s    = regs_q[rs_s];
    assign reg_wsel_s  = rd_s;
    assign DBG_DATA    = regs_q[DBG_SEL];

    assign bus.ADDR_BUS  = addr_q;
    assign bus.DATA_WBUS = wbus_q;
    assign bus.BUS_VALID = valid_q;
    assign bus.BUS_WE    = we_q;
    assign HALTED        = halted_q;

    // Register file update from the internal data bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG && i < 16; i++) begin
                if (reg_we_s && reg_wsel_s == 4'(i)) regs_q[i] <= int_bus_s;
            end
        end
    end

    // State, datapath and bus output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0000_0000;
            z_q      <= 1'b0;
            ain_q    <= '0;
            aout_q   <= '0;
            addr_q   <= '0;
            wbus_q   <= '0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            z_q      <= z_d;
            ain_q    <= ain_d;
            aout_q   <= aout_d;
            addr_q   <= addr_d;
            wbus_q   <= wbus_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            halted_q <= halted_d;
        end
    end

    // Next-state and datapath control; bus requests are launched one cycle ahead so outputs stay registered.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        z_d       = z_q;
        ain_d     = ain_q;
        aout_d    = aout_q;
        addr_d    = addr_q;
        wbus_d    = wbus_q;
        valid_d   = valid_q;
        we_d      = we_q;
        halted_d  = halted_q;
        reg_we_s  = 1'b0;
        int_bus_s = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (RUN) begin
                    state_d = S_FETCH;
                    addr_d  = pc_q;
                    valid_d = 1'b1;
                    we_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (bus.SLAVE_READY) begin
                    ir_d    = 32'(bus.DATA_RBUS);
                    pc_d    = pc_q + ADDR_W'(1);
                    valid_d = 1'b0;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op_s)
                    OP_MOV:         state_d = S_EXE_MOV;
                    OP_LDI:         state_d = S_EXE_LDI;
                    OP_ADD, OP_SUB: state_d = S_ALU_A;
                    OP_LD, OP_ST:   state_d = S_MEM_ADDR;
                    OP_JMP:         state_d = S_EXE_JMP;
                    OP_JZ:          state_d = S_EXE_JZ;
                    OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default:        state_d = S_EXE_NOP;
                endcase
            end
            S_EXE_NOP: state_d = S_DONE;
            S_EXE_MOV: begin
                int_bus_s = rs_val_s;
                reg_we_s  = 1'b1;
                state_d   = S_DONE;
            end
            S_EXE_LDI: begin
                int_bus_s = imm_d_s;
                reg_we_s  = 1'b1;
                state_d   = S_DONE;
            end
            S_EXE_JMP: begin
                pc_d    = imm_a_s;
                state_d = S_DONE;
            end
            S_EXE_JZ: begin
                if (rs_val_s == '0) begin
                    pc_d = imm_a_s;
                end else begin
                    pc_d = pc_q;
                end
                state_d = S_DONE;
            end
            S_ALU_A: begin
                ain_d   = rd_val_s;
                state_d = S_ALU_B;
            end
            S_ALU_B: begin
                if (op_s == OP_SUB) begin
                    aout_d = ain_q - rs_val_s;
                end else begin
                    aout_d = ain_q + rs_val_s;
                end
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                int_bus_s = aout_q;
                reg_we_s  = 1'b1;
                z_d       = (aout_q == '0);
                state_d   = S_DONE;
            end
            S_MEM_ADDR: begin
                valid_d = 1'b1;
                if (op_s == OP_ST) begin
                    addr_d  = ADDR_W'(rd_val_s);
                    wbus_d  = rs_val_s;
                    we_d    = 1'b1;
                    state_d = S_MEM_WR;
                end else begin
                    addr_d  = ADDR_W'(rs_val_s);
                    we_d    = 1'b0;
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (bus.SLAVE_READY) begin
                    int_bus_s = bus.DATA_RBUS;
                    reg_we_s  = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (bus.SLAVE_READY) begin
                    valid_d = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
                state_d  = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_bus_cpu_core_p.sv
// Directed bench for bus_cpu_core_p: small programs in a word memory behind a slave
// with fixed or random wait states; results read back through the debug port.
module tb_bus_cpu_core_p;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RUN = 1'b0;
    logic          HALTED;
    logic [3:0]    DBG_SEL = 4'd0;
    logic [DW-1:0] DBG_DATA;

    bus_cpu_core_p_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

    bus_cpu_core_p #(.DATA_W(DW), .ADDR_W(AW), .NREG(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .RUN(RUN), .bus(bif),
        .HALTED(HALTED), .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA)
    );

    always #5 clk = ~clk;

    logic [31:0]   mem [256];
    bit            rand_mode = 1'b0;
    int            fixed_wait = 0;
    int            wcnt = 0, cur_tgt = 0;
    int            n_comp = 0, n_wr = 0, n_a2 = 0, n_stab = 0, n_viol = 0;
    int            cyc = 0;
    int            rd_t [$];
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;
    int            n_cmp = 0, n_bad = 0;

    function automatic int pick();
        return rand_mode ? int'($urandom_range(3, 0)) : fixed_wait;
    endfunction

    assign bif.SLAVE_READY = bif.BUS_VALID && (wcnt >= cur_tgt);
    assign bif.DATA_RBUS   = (n_wr > 0 && bif.ADDR_BUS == last_wa) ? last_wd : mem[bif.ADDR_BUS[7:0]];

    // Slave: wait-state counter, write capture, read-completion log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            wcnt    <= 0;
            cur_tgt <= pick();
        end else if (bif.BUS_VALID) begin
            if (bif.SLAVE_READY) begin
                wcnt    <= 0;
                cur_tgt <= pick();
                n_comp  <= n_comp + 1;
                if (bif.BUS_WE) begin
                    n_wr    <= n_wr + 1;
                    last_wa <= bif.ADDR_BUS;
                    last_wd <= bif.DATA_WBUS;
                end else begin
                    rd_t.push_back(cyc);
                    if (bif.ADDR_BUS == 32'd2) n_a2 <= n_a2 + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // Request-hold monitor: a pending request must not change until it is accepted.
    logic          pend = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_we = 1'b0;
    always @(negedge clk) begin
        if (pend && bif.BUS_VALID) begin
            n_stab <= n_stab + 1;
            if (bif.ADDR_BUS !== s_addr || bif.BUS_WE !== s_we || bif.DATA_WBUS !== s_data)
                n_viol <= n_viol + 1;
        end
        pend   <= bif.BUS_VALID && !bif.SLAVE_READY && !rst;
        s_addr <= bif.ADDR_BUS;
        s_we   <= bif.BUS_WE;
        s_data <= bif.DATA_WBUS;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [DW-1:0] exp);
        DBG_SEL = idx;
        #1;
        chk(tag, 64'(DBG_DATA), 64'(exp));
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [15:0] imm);
        return {op, rd, rs, 4'h0, imm};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        RUN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_halt(input string tag);
        int k;
        k = 0;
        RUN = 1'b1;
        while (!HALTED && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(HALTED), 64'd1);
    endtask

    task automatic mem_prog_run(input bit rmode, input string tag);
        int w0, v0, s0;
        rand_mode = rmode;
        fixed_wait = 0;
        mem[0] = ins(4'd2, 4'd5, 4'd0, 16'h0040);
        mem[1] = ins(4'd2, 4'd6, 4'd0, 16'h00A5);
        mem[2] = ins(4'd6, 4'd5, 4'd6, 16'h0000);
        mem[3] = ins(4'd5, 4'd7, 4'd5, 16'h0000);
        mem[4] = ins(4'd2, 4'd8, 4'd0, 16'h0041);
        mem[5] = ins(4'd5, 4'd9, 4'd8, 16'h0000);
        mem[6] = ins(4'd9, 4'd0, 4'd0, 16'h0000);
        mem[8'h41] = 32'h0000_1234;
        do_reset();
        w0 = n_wr; v0 = n_viol; s0 = n_stab;
        run_halt({tag, "_halt"});
        chk_reg({tag, "_r7_ld"}, 4'd7, 32'h0000_00A5);
        chk_reg({tag, "_r9_ld"}, 4'd9, 32'h0000_1234);
        chk({tag, "_wr_beats"}, 64'(n_wr - w0), 64'd1);
        chk({tag, "_wr_addr"}, 64'(last_wa), 64'h40);
        chk({tag, "_wr_data"}, 64'(last_wd), 64'hA5);
        chk({tag, "_hold_viol"}, 64'(n_viol - v0), 64'd0);
        if (rmode) chk({tag, "_hold_seen"}, 64'(n_stab > s0), 64'd1);
        else chk({tag, "_hold_none"}, 64'(n_stab - s0), 64'd0);
    endtask

    initial begin
        int s0, c0, k;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset state.
        @(negedge clk);
        chk("rst_valid", 64'(bif.BUS_VALID), 64'd0);
        chk("rst_we", 64'(bif.BUS_WE), 64'd0);
        chk("rst_halted", 64'(HALTED), 64'd0);
        chk("rst_pc", 64'(dut.pc_q), 64'd0);
        for (int i = 0; i < 16; i++) chk_reg("rst_dbg", 4'(i), 32'h0);

        // LDI/LDI/ADD/HALT with zero-wait memory; fetch spacing gives per-instruction latency.
        mem[0] = ins(4'd2, 4'd1, 4'd0, 16'd5);
        mem[1] = ins(4'd2, 4'd2, 4'd0, 16'd3);
        mem[2] = ins(4'd3, 4'd1, 4'd2, 16'd0);
        mem[3] = ins(4'd9, 4'd0, 4'd0, 16'd0);
        do_reset();
        s0 = rd_t.size();
        run_halt("add_halt");
        chk_reg("add_r1", 4'd1, 32'd8);
        chk_reg("add_r2", 4'd2, 32'd3);
        chk("add_z", 64'(dut.z_q), 64'd0);
        chk("add_pc", 64'(dut.pc_q), 64'd4);
        chk("add_nfetch", 64'(rd_t.size() - s0), 64'd4);
        chk("ldi_cycles", 64'(rd_t[s0+1] - rd_t[s0]), 64'd4);
        chk("ldi2_cycles", 64'(rd_t[s0+2] - rd_t[s0+1]), 64'd4);
        chk("add_cycles", 64'(rd_t[s0+3] - rd_t[s0+2]), 64'd6);
        repeat (5) @(negedge clk);
        chk("halt_sticky", 64'(HALTED), 64'd1);
        chk("halt_idle_bus", 64'(bif.BUS_VALID), 64'd0);

        // Immediate zero-extension, subtract wrap, Z on zero result.
        mem[0] = ins(4'd2, 4'd3, 4'd0, 16'hFFFF);
        mem[1] = ins(4'd4, 4'd4, 4'd3, 16'd0);
        mem[2] = ins(4'd4, 4'd3, 4'd3, 16'd0);
        mem[3] = ins(4'd9, 4'd0, 4'd0, 16'd0);
        do_reset();
        run_halt("sub_halt");
        chk_reg("sub_wrap_r4", 4'd4, 32'hFFFF_0001);
        chk_reg("sub_self_r3", 4'd3, 32'h0);
        chk("sub_z", 64'(dut.z_q), 64'd1);

        // Store/load program, zero-wait then random waits.
        mem_prog_run(1'b0, "mem0w");
        mem_prog_run(1'b1, "memrw");

        // Countdown loop: SUB body must run three times.
        rand_mode = 1'b0;
        fixed_wait = 0;
        mem[0] = ins(4'd2, 4'd1, 4'd0, 16'd3);
        mem[1] = ins(4'd2, 4'd2, 4'd0, 16'd1);
        mem[2] = ins(4'd4, 4'd1, 4'd2, 16'd0);
        mem[3] = ins(4'd8, 4'd0, 4'd1, 16'd5);
        mem[4] = ins(4'd7, 4'd0, 4'd0, 16'd2);
        mem[5] = ins(4'd9, 4'd0, 4'd0, 16'd0);
        do_reset();
        s0 = n_a2;
        run_halt("loop_halt");
        chk("loop_body_count", 64'(n_a2 - s0), 64'd3);
        chk("loop_exit_pc", 64'(dut.pc_q), 64'd6);
        chk_reg("loop_r1", 4'd1, 32'd0);

        // RUN dropped during a waited load: load completes, core parks in IDLE.
        fixed_wait = 3;
        mem[0] = ins(4'd2, 4'd1, 4'd0, 16'h0050);
        mem[1] = ins(4'd5, 4'd2, 4'd1, 16'd0);
        mem[2] = ins(4'd2, 4'd3, 4'd0, 16'd7);
        mem[3] = ins(4'd9, 4'd0, 4'd0, 16'd0);
        mem[8'h50] = 32'h0000_BEEF;
        do_reset();
        c0 = n_comp;
        RUN = 1'b1;
        k = 0;
        while (!(bif.BUS_VALID && bif.ADDR_BUS == 32'h50) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ld_req_seen", 64'(bif.BUS_VALID && bif.ADDR_BUS == 32'h50), 64'd1);
        RUN = 1'b0;
        repeat (30) @(negedge clk);
        chk_reg("stop_r2_loaded", 4'd2, 32'h0000_BEEF);
        chk_reg("stop_r3_untouched", 4'd3, 32'h0);
        chk("stop_beats", 64'(n_comp - c0), 64'd3);
        chk("stop_pc", 64'(dut.pc_q), 64'd2);
        chk("stop_valid", 64'(bif.BUS_VALID), 64'd0);
        chk("stop_halted", 64'(HALTED), 64'd0);

        // Resume, then reset in the middle of a waited fetch.
        RUN = 1'b1;
        k = 0;
        while (!(bif.BUS_VALID && bif.ADDR_BUS == 32'd2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("fetch_req_seen", 64'(bif.BUS_VALID && bif.ADDR_BUS == 32'd2), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(bif.BUS_VALID), 64'd0);
        chk("async_rst_pc", 64'(dut.pc_q), 64'd0);
        chk_reg("async_rst_r1", 4'd1, 32'h0);
        RUN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
